// File: rtl/stream_mux_rr.sv
// stream_mux_rr: registered N-channel stream multiplexer with valid/ready
// handshakes. The channel is chosen either by an external index (select
// mode) or by a round-robin arbiter that starts searching at r_rr_ptr.
//
// Handshake semantics (all ports): a word moves on a rising edge where
// valid and ready are both high. A producer must hold data and valid
// stable until it is accepted. in_ready never depends on in_data. The
// output register holds out_data/out_chan/out_valid stable while
// out_valid=1 and out_ready=0.
module stream_mux_rr #(
    parameter  int WIDTH = 8,
    parameter  int NCH   = 8,
    localparam int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_chan;
    logic             r_out_valid;
    logic [SELW-1:0]  r_rr_ptr;

    logic             w_load;
    logic             w_sel_valid;
    logic             w_hi_found;
    logic             w_lo_found;
    logic [SELW-1:0]  w_hi_gnt;
    logic [SELW-1:0]  w_lo_gnt;
    logic             w_gnt_valid;
    logic [SELW-1:0]  w_gnt;
    logic [WIDTH-1:0] w_gnt_data;
    logic [SELW-1:0]  w_rr_next;

    // Output register can take a word when empty or being drained now.
    assign w_load = ~r_out_valid | out_ready;

    // Grant: select mode uses sel directly (out-of-range sel grants nothing);
    // round-robin searches channels >= r_rr_ptr first, then wraps to the
    // lowest valid channel below r_rr_ptr.
    always_comb begin
        w_sel_valid = 1'b0;
        w_hi_found  = 1'b0;
        w_lo_found  = 1'b0;
        w_hi_gnt    = '0;
        w_lo_gnt    = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i)) begin
                w_sel_valid = in_valid[i];
            end
        end
        // Descending scan so the lowest matching channel in each half wins.
        for (int i = NCH - 1; i >= 0; i--) begin
            if (in_valid[i]) begin
                if (SELW'(i) >= r_rr_ptr) begin
                    w_hi_found = 1'b1;
                    w_hi_gnt   = SELW'(i);
                end else begin
                    w_lo_found = 1'b1;
                    w_lo_gnt   = SELW'(i);
                end
            end
        end
        if (mode) begin
            w_gnt_valid = w_hi_found | w_lo_found;
            w_gnt       = w_hi_found ? w_hi_gnt : w_lo_gnt;
        end else begin
            w_gnt_valid = w_sel_valid;
            w_gnt       = sel;
        end
    end

    // Ready fan-out and data selection for the granted channel.
    always_comb begin
        in_ready   = '0;
        w_gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt == SELW'(i)) begin
                in_ready[i] = rst_n & w_load & w_gnt_valid;
                w_gnt_data  = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Explicit wrap so NCH need not be a power of two.
    assign w_rr_next = (w_gnt == SELW'(NCH - 1)) ? '0 : w_gnt + SELW'(1);

    // Output register and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_data  <= '0;
            r_out_chan  <= '0;
            r_out_valid <= 1'b0;
            r_rr_ptr    <= '0;
        end else if (w_load) begin
            if (w_gnt_valid) begin
                r_out_data  <= w_gnt_data;
                r_out_chan  <= w_gnt;
                r_out_valid <= 1'b1;
                if (mode) begin
                    r_rr_ptr <= w_rr_next;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_data  = r_out_data;
    assign out_chan  = r_out_chan;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8x8 instance and a 5x16 instance.
module tb_stream_mux_rr;

    logic clk;

    // Instance A: NCH=8, WIDTH=8
    logic        rst_a;
    logic        mode_a;
    logic [2:0]  sel_a;
    logic [7:0]  dat_a [8];
    logic [63:0] in_data_a;
    logic [7:0]  in_valid_a;
    logic [7:0]  in_ready_a;
    logic [7:0]  out_data_a;
    logic [2:0]  out_chan_a;
    logic        out_valid_a;
    logic        out_ready_a;

    // Instance B: NCH=5, WIDTH=16
    logic        rst_b;
    logic        mode_b;
    logic [2:0]  sel_b;
    logic [15:0] dat_b [5];
    logic [79:0] in_data_b;
    logic [4:0]  in_valid_b;
    logic [4:0]  in_ready_b;
    logic [15:0] out_data_b;
    logic [2:0]  out_chan_b;
    logic        out_valid_b;
    logic        out_ready_b;

    int errors;
    int checks;
    int exp_ch;
    int rr_a [6];

    stream_mux_rr #(.WIDTH(8), .NCH(8)) dut_a (
        .clk       (clk),
        .rst_n     (rst_a),
        .mode      (mode_a),
        .sel       (sel_a),
        .in_data   (in_data_a),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .out_data  (out_data_a),
        .out_chan  (out_chan_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a)
    );

    stream_mux_rr #(.WIDTH(16), .NCH(5)) dut_b (
        .clk       (clk),
        .rst_n     (rst_b),
        .mode      (mode_b),
        .sel       (sel_b),
        .in_data   (in_data_b),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .out_data  (out_data_b),
        .out_chan  (out_chan_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pack per-channel data arrays onto the flat buses.
    always_comb begin
        in_data_a = '0;
        in_data_b = '0;
        for (int i = 0; i < 8; i++) in_data_a[i*8 +: 8] = dat_a[i];
        for (int i = 0; i < 5; i++) in_data_b[i*16 +: 16] = dat_b[i];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rr_a[0] = 2; rr_a[1] = 7; rr_a[2] = 0;
        rr_a[3] = 2; rr_a[4] = 7; rr_a[5] = 0;

        rst_a = 1'b0; mode_a = 1'b1; sel_a = 3'd0;
        in_valid_a = 8'hFF; out_ready_a = 1'b1;
        for (int i = 0; i < 8; i++) dat_a[i] = 8'(8'hA0 + i);
        rst_b = 1'b0; mode_b = 1'b1; sel_b = 3'd0;
        in_valid_b = 5'h1F; out_ready_b = 1'b1;
        for (int i = 0; i < 5; i++) dat_b[i] = 16'(16'hB000 + i);

        // Reset state, with every channel valid
        #1;
        chk("rst_valid", 32'(out_valid_a), 0);
        chk("rst_ready", 32'(in_ready_a), 0);
        chk("rst_data", 32'(out_data_a), 0);
        chk("rst_chan", 32'(out_chan_a), 0);
        chk("rst_ptr", 32'(dut_a.r_rr_ptr), 0);
        chk("rst_b_valid", 32'(out_valid_b), 0);
        chk("rst_b_ready", 32'(in_ready_b), 0);
        step();
        chk("rst_edge_valid", 32'(out_valid_a), 0);
        chk("rst_edge_ready", 32'(in_ready_a), 0);

        // Release: RR mode grants channel 0 first
        rst_a = 1'b1;
        #1;
        chk("rel_ready", 32'(in_ready_a), 32'h01);
        step();
        chk("rel_valid", 32'(out_valid_a), 1);
        chk("rel_chan", 32'(out_chan_a), 0);
        chk("rel_data", 32'(out_data_a), 32'hA0);
        chk("rel_ptr", 32'(dut_a.r_rr_ptr), 1);

        // Select mode, sel=5
        mode_a = 1'b0; sel_a = 3'd5;
        #1;
        chk("sel5_ready", 32'(in_ready_a), 32'h20);
        for (int k = 0; k < 2; k++) begin
            step();
            chk("sel5_data", 32'(out_data_a), 32'hA5);
            chk("sel5_chan", 32'(out_chan_a), 5);
            chk("sel5_valid", 32'(out_valid_a), 1);
            chk("sel5_ready_hold", 32'(in_ready_a), 32'h20);
            chk("sel5_ptr", 32'(dut_a.r_rr_ptr), 1);
        end

        // Round-robin over channels 0,2,7 starting from rr_ptr=1
        mode_a = 1'b1; in_valid_a = 8'b1000_0101;
        for (int k = 0; k < 6; k++) begin
            exp_ch = rr_a[k];
            #1;
            chk("rr_ready", 32'(in_ready_a), 32'(1) << exp_ch);
            step();
            chk("rr_chan", 32'(out_chan_a), 32'(exp_ch));
            chk("rr_data", 32'(out_data_a), 32'(8'hA0 + exp_ch));
            chk("rr_valid", 32'(out_valid_a), 1);
        end
        chk("rr_ptr_end", 32'(dut_a.r_rr_ptr), 1);

        // Backpressure: hold channel 3 word, then reload with no bubble
        mode_a = 1'b0; sel_a = 3'd3; dat_a[3] = 8'h3C; in_valid_a = 8'hFF;
        #1;
        chk("bp_ready_in", 32'(in_ready_a), 32'h08);
        step();
        chk("bp_chan", 32'(out_chan_a), 3);
        chk("bp_data", 32'(out_data_a), 32'h3C);
        out_ready_a = 1'b0; sel_a = 3'd4;
        #1;
        chk("bp_ready_blk", 32'(in_ready_a), 0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("bp_hold_valid", 32'(out_valid_a), 1);
            chk("bp_hold_chan", 32'(out_chan_a), 3);
            chk("bp_hold_data", 32'(out_data_a), 32'h3C);
            chk("bp_hold_ready", 32'(in_ready_a), 0);
        end
        out_ready_a = 1'b1;
        #1;
        chk("bp_drain_ready", 32'(in_ready_a), 32'h10);
        step();
        chk("bp_next_valid", 32'(out_valid_a), 1);
        chk("bp_next_chan", 32'(out_chan_a), 4);
        chk("bp_next_data", 32'(out_data_a), 32'hA4);

        // No grant: out_valid falls, data/chan hold
        sel_a = 3'd6; in_valid_a = 8'hBF;
        #1;
        chk("ng_ready", 32'(in_ready_a), 0);
        step();
        chk("ng_valid", 32'(out_valid_a), 0);
        chk("ng_chan", 32'(out_chan_a), 4);
        chk("ng_data", 32'(out_data_a), 32'hA4);

        // Asynchronous reset while a word is held under backpressure
        mode_a = 1'b1; in_valid_a = 8'hFF;
        #1;
        chk("ar_ready", 32'(in_ready_a), 32'h02);
        step();
        chk("ar_chan", 32'(out_chan_a), 1);
        chk("ar_ptr", 32'(dut_a.r_rr_ptr), 2);
        out_ready_a = 1'b0;
        step();
        chk("ar_held", 32'(out_valid_a), 1);
        #2;
        rst_a = 1'b0;
        #1;
        chk("ar_valid", 32'(out_valid_a), 0);
        chk("ar_ptr0", 32'(dut_a.r_rr_ptr), 0);
        chk("ar_in_ready", 32'(in_ready_a), 0);
        chk("ar_data", 32'(out_data_a), 0);
        step();
        in_valid_a = 8'h00; out_ready_a = 1'b1; rst_a = 1'b1;
        step();
        chk("ar_no_stale", 32'(out_valid_a), 0);
        in_valid_a = 8'hFF;
        #1;
        chk("ar_post_ready", 32'(in_ready_a), 32'h01);
        step();
        chk("ar_post_chan", 32'(out_chan_a), 0);

        // Instance B: NCH=5 wraps at 4
        rst_b = 1'b1;
        for (int k = 0; k < 6; k++) begin
            exp_ch = k % 5;
            #1;
            chk("b_rr_ready", 32'(in_ready_b), 32'(1) << exp_ch);
            step();
            chk("b_rr_chan", 32'(out_chan_b), 32'(exp_ch));
            chk("b_rr_data", 32'(out_data_b), 32'(16'hB000 + exp_ch));
            chk("b_rr_valid", 32'(out_valid_b), 1);
        end
        mode_b = 1'b0; sel_b = 3'd6;
        #1;
        chk("b_sel6_ready", 32'(in_ready_b), 0);
        step();
        chk("b_sel6_valid", 32'(out_valid_b), 0);
        chk("b_sel6_chan", 32'(out_chan_b), 0);
        chk("b_sel6_data", 32'(out_data_b), 32'hB000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
